// File: rtl/channel_error_injector_if.sv
// Symbol bus between the convolutional encoder, the error-injecting channel and the Viterbi decoder.
// Valid-only stream: the channel cannot stall. A symbol is accepted on any clock edge where valid_i=1;
// valid_o is valid_i delayed one cycle, and d_out/err_mask_o are meaningful only while valid_o=1.
interface channel_error_injector_if;
  logic       valid_i;
  logic [1:0] d_in;
  logic       valid_o;
  logic [1:0] d_out;
  logic [1:0] err_mask_o;

  modport master (output valid_i, d_in, input valid_o, d_out, err_mask_o);
  modport slave  (input valid_i, d_in, output valid_o, d_out, err_mask_o);
endinterface

// File: rtl/channel_error_injector.sv
// Programmable bit-error channel: clean pass-through, periodic bursts or LFSR-driven random flips,
// with a saturating count of injected bit errors. One register stage from d_in to d_out.
module channel_error_injector #(
  parameter int          PERIOD_W = 8,
  parameter int          CNT_W    = 16,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  channel_error_injector_if.slave sym,
  input  logic [1:0]          mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic [3:0]          burst_len,
  input  logic [1:0]          bit_sel,
  input  logic [8:0]          thresh,
  output logic [CNT_W-1:0]    err_count_o,
  output logic [PERIOD_W-1:0] dbg_pos,
  output logic [3:0]          dbg_burst_rem,
  output logic [15:0]         dbg_lfsr
);

  localparam logic [1:0] MODE_CLEAN  = 2'b00;
  localparam logic [1:0] MODE_BURST  = 2'b01;
  localparam logic [1:0] MODE_RANDOM = 2'b10;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  logic [PERIOD_W-1:0] pos, pos_next;
  logic [3:0]          burst_rem, rem_next, eff_rem;
  logic [15:0]         lfsr, lfsr_next;
  logic [1:0]          mask, rand_mask;
  logic                burst_start;
  logic [CNT_W:0]      cnt_sum;
  logic [CNT_W-1:0]    cnt_next;

  always_comb begin
    burst_start = (pos == '0) && (period != '0);
    // A burst start reloads rather than adds, so overlapping bursts never stack.
    eff_rem     = burst_start ? burst_len : burst_rem;
    rand_mask   = {({1'b0, lfsr[15:8]} < thresh), ({1'b0, lfsr[7:0]} < thresh)};
    mask        = 2'b00;
    rem_next    = 4'd0;
    case (mode)
      MODE_BURST: begin
        if (eff_rem != 4'd0) begin
          mask     = bit_sel;
          rem_next = eff_rem - 4'd1;
        end
      end
      MODE_RANDOM: mask = rand_mask;
      MODE_CLEAN:  mask = 2'b00;
      default:     mask = 2'b00;
    endcase

    // Comparing with >= lets a shrunken period pull a stale pos back to 0.
    if (period == '0) begin
      pos_next = '0;
    end else if (pos >= period - PERIOD_W'(1)) begin
      pos_next = '0;
    end else begin
      pos_next = pos + PERIOD_W'(1);
    end

    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);

    cnt_sum  = {1'b0, err_count_o} + (CNT_W+1)'(mask[0]) + (CNT_W+1)'(mask[1]);
    cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym.valid_o    <= 1'b0;
      sym.d_out      <= 2'b00;
      sym.err_mask_o <= 2'b00;
      err_count_o    <= '0;
      pos            <= '0;
      burst_rem      <= 4'd0;
      lfsr           <= SEED;
    end else if (clear) begin
      sym.valid_o    <= 1'b0;
      sym.d_out      <= 2'b00;
      sym.err_mask_o <= 2'b00;
      err_count_o    <= '0;
      pos            <= '0;
      burst_rem      <= 4'd0;
      lfsr           <= SEED;
    end else begin
      sym.valid_o <= sym.valid_i;
      if (sym.valid_i) begin
        sym.d_out      <= sym.d_in ^ mask;
        sym.err_mask_o <= mask;
        err_count_o    <= cnt_next;
        pos            <= pos_next;
        burst_rem      <= rem_next;
        lfsr           <= lfsr_next;
      end
    end
  end

  assign dbg_pos       = pos;
  assign dbg_burst_rem = burst_rem;
  assign dbg_lfsr      = lfsr;

endmodule

// File: tb/tb_channel_error_injector.sv
// Directed bench for channel_error_injector: a table of per-symbol vectors plus hand-written
// sequences for valid gaps, LFSR repeatability, counter saturation and mid-stream reset.
module tb_channel_error_injector;

  localparam logic [15:0] SEED = 16'hACE1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       clear = 1'b0;
  logic       valid_i = 1'b0;
  logic [1:0] d_in = 2'b00;
  logic [1:0] mode = 2'b00;
  logic [7:0] period = 8'd0;
  logic [3:0] burst_len = 4'd0;
  logic [1:0] bit_sel = 2'b00;
  logic [8:0] thresh = 9'd0;

  channel_error_injector_if bus_a ();
  channel_error_injector_if bus_b ();
  assign bus_a.valid_i = valid_i;
  assign bus_a.d_in    = d_in;
  assign bus_b.valid_i = valid_i;
  assign bus_b.d_in    = d_in;

  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic [7:0]  pos_a, pos_b;
  logic [3:0]  rem_a, rem_b;
  logic [15:0] lfsr_a, lfsr_b;

  channel_error_injector #(.PERIOD_W(8), .CNT_W(16), .SEED(SEED)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .sym(bus_a.slave), .mode(mode), .period(period),
    .burst_len(burst_len), .bit_sel(bit_sel), .thresh(thresh), .err_count_o(cnt_a),
    .dbg_pos(pos_a), .dbg_burst_rem(rem_a), .dbg_lfsr(lfsr_a)
  );

  channel_error_injector #(.PERIOD_W(8), .CNT_W(4), .SEED(SEED)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .sym(bus_b.slave), .mode(mode), .period(period),
    .burst_len(burst_len), .bit_sel(bit_sel), .thresh(thresh), .err_count_o(cnt_b),
    .dbg_pos(pos_b), .dbg_burst_rem(rem_b), .dbg_lfsr(lfsr_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          clr;
    logic [1:0]  mode;
    logic [7:0]  period;
    logic [3:0]  blen;
    logic [1:0]  bsel;
    logic [8:0]  thresh;
    logic [1:0]  din;
    logic [1:0]  exp_mask;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit clr, input int m, input int per, input int bl, input int bs,
                              input int th, input int din, input int em, input int ec);
    vec_t v;
    v.clr = clr; v.mode = 2'(m); v.period = 8'(per); v.blen = 4'(bl); v.bsel = 2'(bs);
    v.thresh = 9'(th); v.din = 2'(din); v.exp_mask = 2'(em); v.exp_cnt = 16'(ec);
    vecs.push_back(v);
  endfunction

  // Reference LFSR derived from the channel description: Galois right shift, taps 0xB400.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_sym(input logic [1:0] m, input logic [7:0] per, input logic [3:0] bl,
                           input logic [1:0] bs, input logic [8:0] th, input logic [1:0] din);
    @(negedge clk);
    clear = 1'b0; valid_i = 1'b1; d_in = din;
    mode = m; period = per; burst_len = bl; bit_sel = bs; thresh = th;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle(input logic [1:0] din);
    @(negedge clk);
    clear = 1'b0; valid_i = 1'b0; d_in = din;
    @(posedge clk); #1;
  endtask

  // Clear is asserted together with a symbol that would be corrupted, to show clear wins.
  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1; valid_i = 1'b1; d_in = 2'b11; mode = 2'b10; thresh = 9'd256;
    @(posedge clk); #1;
    check("clear_valid_o", 32'(bus_a.valid_o), 32'd0);
    check("clear_d_out", 32'(bus_a.d_out), 32'd0);
    check("clear_count", 32'(cnt_a), 32'd0);
    check("clear_lfsr", 32'(lfsr_a), 32'(SEED));
    @(negedge clk);
    clear = 1'b0; valid_i = 1'b0;
  endtask

  task automatic sym_check(input string tag, input logic [1:0] em, input logic [15:0] ec);
    logic [1:0] exp_d;
    exp_d = exp_q.pop_front();
    check({tag, "_valid_o"}, 32'(bus_a.valid_o), 32'd1);
    check({tag, "_d_out"}, 32'(bus_a.d_out), 32'(exp_d));
    check({tag, "_mask"}, 32'(bus_a.err_mask_o), 32'(em));
    check({tag, "_count"}, 32'(cnt_a), 32'(ec));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    int c;
    logic [15:0] s;
    logic [1:0]  m_exp;
    logic [1:0]  din_r;
    logic [1:0]  din_hist[20];

    // Mode 00: straight pass-through of incrementing symbols.
    for (int i = 0; i < 20; i++) add(i == 0, 0, 0, 0, 0, 0, i, 0, 0);
    // Mode 11 behaves as clean even with aggressive burst/random config.
    for (int i = 0; i < 5; i++) add(0, 3, 1, 5, 3, 256, 3 - (i % 4), 0, 0);
    // Mode 01, period 15, burst 2 on bit0: symbols 0,1,15,16 corrupted.
    c = 0;
    for (int i = 0; i < 30; i++) begin
      m_exp = (i == 0 || i == 1 || i == 15 || i == 16) ? 2'b01 : 2'b00;
      c += m_exp[0];
      add(i == 0, 1, 15, 2, 1, 0, i, m_exp, c);
    end
    // Mode 01, period 4, burst 6: reloads overlap so every symbol is hit on both bits.
    for (int i = 0; i < 12; i++) add(i == 0, 1, 4, 6, 3, 0, i, 3, 2 * (i + 1));
    // period=0 disables bursts; burst_len=0 gives empty bursts.
    for (int i = 0; i < 6; i++) add(i == 0, 1, 0, 3, 3, 0, i, 0, 0);
    for (int i = 0; i < 6; i++) add(i == 0, 1, 2, 0, 3, 0, i, 0, 0);
    // Mode 10 threshold extremes.
    for (int i = 0; i < 50; i++) add(i == 0, 2, 0, 0, 0, 0, i, 0, 0);
    for (int i = 0; i < 10; i++) add(i == 0, 2, 0, 0, 0, 256, i, 3, 2 * (i + 1));
    // Mode 10, thresh 200, first four states from SEED: ACE1, E270, 7138, 389C.
    for (int r = 0; r < 2; r++) begin
      add(1, 2, 0, 0, 0, 200, 0, 2'b10, 1);
      add(0, 2, 0, 0, 0, 200, 1, 2'b01, 2);
      add(0, 2, 0, 0, 0, 200, 2, 2'b11, 4);
      add(0, 2, 0, 0, 0, 200, 3, 2'b11, 6);
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_o", 32'(bus_a.valid_o), 32'd0);
    check("rst_d_out", 32'(bus_a.d_out), 32'd0);
    check("rst_mask", 32'(bus_a.err_mask_o), 32'd0);
    check("rst_count", 32'(cnt_a), 32'd0);
    check("rst_pos", 32'(pos_a), 32'd0);
    check("rst_burst_rem", 32'(rem_a), 32'd0);
    check("rst_lfsr", 32'(lfsr_a), 32'(SEED));
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[k]) begin
      if (vecs[k].clr) do_clear();
      exp_q.push_back(vecs[k].din ^ vecs[k].exp_mask);
      drive_sym(vecs[k].mode, vecs[k].period, vecs[k].blen, vecs[k].bsel, vecs[k].thresh, vecs[k].din);
      sym_check($sformatf("vec%0d", k), vecs[k].exp_mask, vecs[k].exp_cnt);
    end

    // Valid gaps in mode 01, period 3, burst 1 on bit1.
    do_clear();
    exp_q.push_back(2'b11);
    drive_sym(2'b01, 8'd3, 4'd1, 2'b10, 9'd0, 2'b01);
    sym_check("gap_s0", 2'b10, 16'd1);
    check("gap_s0_pos", 32'(pos_a), 32'd1);
    check("gap_s0_rem", 32'(rem_a), 32'd0);
    for (int g = 0; g < 2; g++) begin
      idle_cycle(2'b00);
      check($sformatf("gap_idle%0d_valid_o", g), 32'(bus_a.valid_o), 32'd0);
      check($sformatf("gap_idle%0d_d_out", g), 32'(bus_a.d_out), 32'd3);
      check($sformatf("gap_idle%0d_mask", g), 32'(bus_a.err_mask_o), 32'd2);
      check($sformatf("gap_idle%0d_pos", g), 32'(pos_a), 32'd1);
      check($sformatf("gap_idle%0d_count", g), 32'(cnt_a), 32'd1);
    end
    exp_q.push_back(2'b10);
    drive_sym(2'b01, 8'd3, 4'd1, 2'b10, 9'd0, 2'b10);
    sym_check("gap_s1", 2'b00, 16'd1);
    exp_q.push_back(2'b00);
    drive_sym(2'b01, 8'd3, 4'd1, 2'b10, 9'd0, 2'b00);
    sym_check("gap_s2", 2'b00, 16'd1);
    check("gap_s2_pos", 32'(pos_a), 32'd0);
    exp_q.push_back(2'b01);
    drive_sym(2'b01, 8'd3, 4'd1, 2'b10, 9'd0, 2'b11);
    sym_check("gap_s3", 2'b10, 16'd2);

    // Period shrink below current pos: pos wraps to 0 on the next symbol.
    do_clear();
    for (int i = 0; i < 5; i++) drive_sym(2'b00, 8'd10, 4'd0, 2'b00, 9'd0, 2'b00);
    check("shrink_pos_before", 32'(pos_a), 32'd5);
    drive_sym(2'b00, 8'd3, 4'd0, 2'b00, 9'd0, 2'b00);
    check("shrink_pos_after", 32'(pos_a), 32'd0);

    // Random mode repeatability against the reference LFSR, two runs separated by clear.
    for (int i = 0; i < 20; i++) din_hist[i] = 2'($urandom_range(0, 3));
    for (int r = 0; r < 2; r++) begin
      do_clear();
      s = SEED;
      c = 0;
      for (int i = 0; i < 20; i++) begin
        m_exp = {(s[15:8] < 8'd100), (s[7:0] < 8'd100)};
        c += m_exp[0] + m_exp[1];
        din_r = din_hist[i];
        exp_q.push_back(din_r ^ m_exp);
        drive_sym(2'b10, 8'd0, 4'd0, 2'b00, 9'd100, din_r);
        sym_check($sformatf("rand_r%0d_s%0d", r, i), m_exp, 16'(c));
        s = lfsr_step(s);
      end
      check($sformatf("rand_r%0d_lfsr", r), 32'(lfsr_a), 32'(s));
    end

    // Saturation on the 4-bit counter instance.
    do_clear();
    for (int i = 0; i < 10; i++) begin
      drive_sym(2'b10, 8'd0, 4'd0, 2'b00, 9'd256, 2'(i));
      check($sformatf("sat_s%0d_count", i), 32'(cnt_b), (2 * (i + 1) > 15) ? 32'd15 : 32'(2 * (i + 1)));
    end

    // Asynchronous reset asserted mid-stream, away from any clock edge.
    @(negedge clk);
    valid_i = 1'b1; d_in = 2'b01;
    #2 rst = 1'b0;
    #1;
    check("arst_valid_o", 32'(bus_a.valid_o), 32'd0);
    check("arst_d_out", 32'(bus_a.d_out), 32'd0);
    check("arst_mask", 32'(bus_a.err_mask_o), 32'd0);
    check("arst_count_a", 32'(cnt_a), 32'd0);
    check("arst_count_b", 32'(cnt_b), 32'd0);
    check("arst_lfsr", 32'(lfsr_b), 32'(SEED));
    @(negedge clk);
    rst = 1'b1; valid_i = 1'b0;
    exp_q.push_back(2'b10);
    drive_sym(2'b10, 8'd0, 4'd0, 2'b00, 9'd200, 2'b00);
    sym_check("post_rst_s0", 2'b10, 16'd1);
    exp_q.push_back(2'b00);
    drive_sym(2'b10, 8'd0, 4'd0, 2'b00, 9'd200, 2'b01);
    sym_check("post_rst_s1", 2'b01, 16'd2);

    // ---------------- final report ----------------
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
